div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle sequencer for the RISC-V M-extension divide/remainder ops (DIV, DIVU, REM, REMU). It replaces the combinational divider path behind ALU select codes 17–20 with a 32-iteration radix-2 restoring divider and a start/busy/valid handshake, so the pipeline stalls instead of carrying a long combinational divide path. It sits beside the ALU in the execute stage: it receives the same operands and select code, and its result is muxed into the writeback path when `valid` is high.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op`  in  5  ALU select code: 17 DIV, 18 DIVU, 19 REM, 20 REMU; other codes are ignored.
- `A`  in  32  dividend; sampled with `start`.
- `B`  in  32  divisor; sampled with `start`.
- `flush`  in  1  synchronous abort from pipeline kill.
- `busy`  out  1  high in CALC and FIX.
- `valid`  out  1  one-cycle pulse in DONE; `result` is valid in that cycle.
- `result`  out  32  registered; holds its value until the next DONE.

## Operation
- States:
  - IDLE: waiting for a request.
  - CALC: 32 iterations; a 5-bit counter counts down from 31.
  - FIX: sign correction and op selection.
  - DONE: one cycle with `valid=1`.
- Accept condition: `start=1`, `op` in 17..20, `flush=0`, and state is IDLE or DONE. On accept, latch `op`, `A` and `B`.
- Signed ops (17, 19):
  - Operands are converted to their magnitudes.
  - `neg_q = A[31]^B[31]`.
  - `neg_r = A[31]`.
- Unsigned ops (18, 20): use the raw operands, with `neg_q = neg_r = 0`.
- Special cases bypass CALC and FIX and go straight to DONE:
  - `B==0`: quotient = 0xFFFFFFFF and remainder = A, for both signed and unsigned ops.
  - Signed overflow (`A==0x80000000 && B==0xFFFFFFFF`, ops 17 and 19 only): quotient = 0x80000000 and remainder = 0.
- CALC iteration, per cycle:
  - `{rem,quo} <= {rem,quo}<<1`.
  - If the shifted `rem >= |B|` (a 33-bit compare), subtract `|B|` and set `quo[0]=1`.
  - Exit to FIX when the counter reaches 0.
- FIX:
  - Compute `q = neg_q ? -quo : quo` and `r = neg_r ? -rem : rem`.
  - Select q for ops 17/18 and r for ops 19/20.
  - Register the selection into `result` on the FIX→DONE edge.
- DONE: if accept → latch the new request and go to CALC, or to DONE for a special case (back-to-back results are allowed). Otherwise go to IDLE.
- `start` while busy is ignored. A `start` with an invalid op is ignored, with no state change.
- `flush=1` returns to IDLE on the next edge from any state:
  - No `valid` is produced and `result` is unchanged.
  - Flush wins over a simultaneous `start`.
  - Flush in IDLE has no effect.
- Reset (asynchronous, any state, including mid-CALC):
  - state = IDLE, `busy=0`, `valid=0`, `result=0`.
  - Counter and internal registers = 0.

## Timing
- Normal op, with the request accepted at edge E0:
  - CALC during E0..E32 (32 iteration edges E1–E32).
  - FIX after E32.
  - DONE after E33, so `valid` is high in the cycle following E33.
  - Latency from accept to valid: 33 cycles.
  - `busy` is high from after E0 until E33.
- Special case: DONE directly after E0, so `valid` is high in the next cycle (latency 1) and `busy` never rises.
- `valid` is exactly one cycle wide, never asserts with `busy`, and never asserts without a preceding accept.
- Operands may change after the accept edge without affecting the result.
- Throughput: one op per 34 cycles when a new `start` is issued in DONE.

## Test plan
- DIVU A=100, B=7 → `valid` 33 cycles after accept, `result`=14; REMU with the same operands → 2; `busy` high for exactly 33 cycles.
- DIV A=0xFFFFFFF9 (−7), B=2 → 0xFFFFFFFD (−3); REM → 0xFFFFFFFF (−1); REM A=7, B=0xFFFFFFFE → 1.
- DIV A=5, B=0 → 0xFFFFFFFF with latency 1 and `busy` never high; REMU A=5, B=0 → 5.
- DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000 with latency 1; REM → 0; DIVU with the same operands → 0 after 33 cycles.
- Flush, start and invalid op:
  - Start DIVU 0xFFFFFFFF/3, assert `flush` at cycle 10 of CALC → `busy` low next cycle, no `valid`, `result` unchanged.
  - Then DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.
  - Simultaneous `flush`+`start` → no accept.
  - `start` with op=8 → ignored.
- Reset and back-to-back:
  - Pulse `rst_n` low mid-CALC → `busy`, `valid` and `result` read 0 immediately.
  - `start` asserted while busy → ignored.
  - Back-to-back `start` in DONE → second result 34 cycles after the first.

Source files
------------

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// A request is accepted in IDLE or DONE; 32 shift/subtract iterations run in
// CALC, FIX applies the sign correction and op select, and DONE pulses valid.
// Divide-by-zero and signed overflow skip the iterations and finish at once.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [4:0] OP_DIV  = 5'd17;
    localparam logic [4:0] OP_DIVU = 5'd18;
    localparam logic [4:0] OP_REM  = 5'd19;
    localparam logic [4:0] OP_REMU = 5'd20;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   div_q, div_d;     // divisor magnitude
    logic               neg_q_q, neg_q_d; // negate quotient in FIX
    logic               neg_r_q, neg_r_d; // negate remainder in FIX
    logic               sel_r_q, sel_r_d; // 1: REM/REMU, 0: DIV/DIVU
    logic [WIDTH-1:0]   result_q, result_d;

    // Request decode and operand preparation from the live inputs
    logic               op_ok, accept, is_signed, is_rem;
    logic               b_zero, ovf;
    logic [WIDTH-1:0]   a_abs, b_abs;

    // Iteration datapath: shifted partial remainder is one bit wider than |B|
    logic [WIDTH:0]     rem_sh;
    logic               ge;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign op_ok     = (op >= OP_DIV) && (op <= OP_REMU);
    assign accept    = start && op_ok && !flush &&
                       (state_q == S_IDLE || state_q == S_DONE);
    assign is_signed = (op == OP_DIV) || (op == OP_REM);
    assign is_rem    = (op == OP_REM) || (op == OP_REMU);
    assign a_abs     = (is_signed && A[WIDTH-1]) ? -A : A;
    assign b_abs     = (is_signed && B[WIDTH-1]) ? -B : B;
    assign b_zero    = (B == '0);
    assign ovf       = is_signed && (A == MIN_NEG) && (B == '1);

    assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
    assign ge        = rem_sh >= {1'b0, div_q};
    // When ge holds the difference is below |B|, so the low WIDTH bits suffice
    assign diff      = rem_sh[WIDTH-1:0] - div_q;

    assign q_fix     = neg_q_q ? -quo_q : quo_q;
    assign r_fix     = neg_r_q ? -rem_q : rem_q;

    // Next-state and datapath updates; flush overrides everything else
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        sel_r_d  = sel_r_q;
        result_d = result_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    // DONE falls back to IDLE unless a new request arrives
                    state_d = S_IDLE;
                    if (accept) begin
                        sel_r_d = is_rem;
                        if (b_zero) begin
                            result_d = is_rem ? A : '1;
                            state_d  = S_DONE;
                        end else if (ovf) begin
                            result_d = is_rem ? '0 : MIN_NEG;
                            state_d  = S_DONE;
                        end else begin
                            rem_d   = '0;
                            quo_d   = a_abs;
                            div_d   = b_abs;
                            neg_q_d = is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_r_d = is_signed && A[WIDTH-1];
                            cnt_d   = CNT_W'(WIDTH - 1);
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_d = ge ? diff : rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], ge};
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) state_d = S_FIX;
                end
                S_FIX: begin
                    result_d = sel_r_q ? r_fix : q_fix;
                    state_d  = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            sel_r_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            sel_r_q  <= sel_r_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign valid  = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed vector table, hand-written flush/reset/
// back-to-back sequences, and randomized ops against an arithmetic model.
// "vcyc" is the number of cycles from the cycle start is presented to the
// cycle valid is seen: 1 for the bypass cases, 34 (accept edge + 33) otherwise.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [4:0]  op;
    logic [31:0] A, B;
    logic        busy, valid;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    div_sequencer #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .flush  (flush),
        .busy   (busy),
        .valid  (valid),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          vcyc;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: RISC-V M-extension results computed with plain arithmetic
    function automatic logic [31:0] ref_res(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        bit sgn, remop;
        sa    = a;
        sb    = b;
        sgn   = (o == 5'd17) || (o == 5'd19);
        remop = (o == 5'd19) || (o == 5'd20);
        if (b == 32'd0) return remop ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return remop ? 32'd0 : 32'h8000_0000;
        if (sgn) return remop ? sa % sb : sa / sb;
        return remop ? a % b : a / b;
    endfunction

    function automatic int ref_vcyc(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        bit sgn;
        sgn = (o == 5'd17) || (o == 5'd19);
        if (b == 32'd0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one request, scramble operands afterwards, wait for valid.
    // poke > 0 pulses a junk start at that cycle while the op is in flight.
    task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke, output logic [31:0] res, output int vcyc, output int bcnt);
        bit seen, overlap;
        seen = 0; overlap = 0; vcyc = 0; bcnt = 0; res = '0;
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom;
        for (int t = 1; t <= 100; t++) begin
            if (valid && busy) overlap = 1;
            if (valid) begin
                seen = 1; vcyc = t; res = result;
                break;
            end
            if (busy) bcnt++;
            if (t == poke) begin
                start = 1'b1; op = 5'd18; A = 32'd1000; B = 32'd1;
            end
            if (t == poke + 1) start = 1'b0;
            @(negedge clk);
        end
        chk("valid_seen", 32'(seen), 32'd1);
        chk("valid_busy_overlap", 32'(overlap), 32'd0);
        @(negedge clk);
        chk("valid_one_cycle", 32'(valid), 32'd0);
    endtask

    vec_t        vecs[$];
    logic [31:0] res, last_exp, ea, eb;
    logic [4:0]  eo;
    int          vc, bc, t2;
    bit          bad;

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; A = '0; B = '0;

        vecs = '{
            '{5'd18, 32'd100,        32'd7,          32'd14,         34},
            '{5'd20, 32'd100,        32'd7,          32'd2,          34},
            '{5'd17, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34},
            '{5'd19, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34},
            '{5'd19, 32'd7,          32'hFFFF_FFFE,  32'd1,          34},
            '{5'd17, 32'd5,          32'd0,          32'hFFFF_FFFF,  1},
            '{5'd20, 32'd5,          32'd0,          32'd5,          1},
            '{5'd19, 32'hFFFF_FFF5,  32'd0,          32'hFFFF_FFF5,  1},
            '{5'd17, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1},
            '{5'd19, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1},
            '{5'd18, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34},
            '{5'd18, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34}
        };

        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_result", result, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, res, vc, bc);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(vc), 32'(vecs[i].vcyc));
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bc), (vecs[i].vcyc == 34) ? 32'd33 : 32'd0);
            last_exp = vecs[i].exp;
        end

        // Flush at CALC cycle 10: no valid, result holds
        @(negedge clk);
        op = 5'd18; A = 32'hFFFF_FFFF; B = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("flush_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_after", 32'(busy), 32'd0);
        chk("flush_result_held", result, last_exp);
        bad = 0;
        for (int t = 0; t < 40; t++) begin
            if (valid || busy) bad = 1;
            @(negedge clk);
        end
        chk("flush_no_valid", 32'(bad), 32'd0);

        run_op(5'd18, 32'hFFFF_FFFF, 32'd1, 0, res, vc, bc);
        chk("post_flush_result", res, 32'hFFFF_FFFF);
        chk("post_flush_latency", 32'(vc), 32'd34);
        last_exp = 32'hFFFF_FFFF;

        // Flush together with start: nothing accepted
        @(negedge clk);
        op = 5'd18; A = 32'd10; B = 32'd0; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        bad = 0;
        for (int t = 0; t < 5; t++) begin
            if (valid || busy) bad = 1;
            @(negedge clk);
        end
        chk("flush_start_no_accept", 32'(bad), 32'd0);

        // Invalid op code: ignored (B=0 would otherwise give valid next cycle)
        op = 5'd8; A = 32'd10; B = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("badop_valid", 32'(valid), 32'd0);
        chk("badop_busy", 32'(busy), 32'd0);
        chk("badop_result", result, last_exp);

        // Start while busy is ignored
        run_op(5'd18, 32'd100, 32'd7, 5, res, vc, bc);
        chk("busy_start_result", res, 32'd14);
        chk("busy_start_latency", 32'(vc), 32'd34);

        // Back-to-back: new start in DONE, next valid 34 cycles later
        @(negedge clk);
        op = 5'd18; A = 32'd100; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bad = 1;
        for (int t = 0; t < 100; t++) begin
            if (valid) begin bad = 0; break; end
            @(negedge clk);
        end
        chk("b2b_first_seen", 32'(bad), 32'd0);
        chk("b2b_first_result", result, 32'd14);
        op = 5'd20; A = 32'd100; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t2 = 0;
        for (int t = 1; t <= 100; t++) begin
            if (valid) begin t2 = t; break; end
            @(negedge clk);
        end
        chk("b2b_spacing", 32'(t2), 32'd34);
        chk("b2b_second_result", result, 32'd2);

        // Asynchronous reset mid-CALC clears outputs immediately
        @(negedge clk);
        op = 5'd18; A = 32'd100; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_valid", 32'(valid), 32'd0);
        chk("async_rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized ops against the model
        for (int i = 0; i < 60; i++) begin
            eo = 5'(17 + $urandom_range(0, 3));
            ea = pick();
            eb = pick();
            run_op(eo, ea, eb, 0, res, vc, bc);
            chk($sformatf("rnd%0d_op%0d_%h_%h", i, eo, ea, eb), res, ref_res(eo, ea, eb));
            chk($sformatf("rnd%0d_latency", i), 32'(vc), 32'(ref_vcyc(eo, ea, eb)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
